// File: rtl/uart_load_pkg.sv
// Shared constants for the UART data-memory loader: FSM encoding, con_* port
// widths and a constant clog2 used to size the baud counter.
package uart_load_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int CON_ADDR_W     = 11;
    localparam int CON_DATA_W     = 32;
    localparam int BYTES_PER_WORD = 4;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop RX synchronizer, START/DATA/STOP FSM and
// baud counter. Emits one-cycle pulses for a good byte or a bad stop bit.
module uart_rx_byte
    import uart_load_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o,
    output logic       busy_o
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_d;
    logic             ferr_d;

    // Stop-bit outcome is decoded combinationally so the packer can register
    // the word write on the very edge that samples the stop bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_d = 3'd0;
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    valid_d = rx_sync_q;
                    ferr_d  = ~rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    assign rx_byte_o  = shift_q;
    assign rx_valid_o = valid_d;
    assign rx_ferr_o  = ferr_d;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_datamemload.sv
// Loads data memory from a UART host: packs received bytes little-endian into
// 32-bit words and writes them to sequential word addresses via the con_* port.
module uart_datamemload
    import uart_load_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_WORDS    = 2048
) (
    input  logic                      CLK,
    input  logic                      nrst,
    input  logic                      RX,
    output logic [CON_ADDR_W-1:0]     con_addr,
    output logic [BYTES_PER_WORD-1:0] con_write,
    output logic [CON_DATA_W-1:0]     con_in,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_err
);

    localparam logic [CON_ADDR_W-1:0] LAST_ADDR = CON_ADDR_W'(NUM_WORDS - 1);

    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  rx_ferr;

    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           lanes_q, lanes_d;
    logic [CON_ADDR_W-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [CON_DATA_W-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (CLK),
        .rst_ni     (nrst),
        .rx_i       (RX),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .rx_ferr_o  (rx_ferr),
        .busy_o     (busy)
    );

    // The fourth byte bypasses the lane registers straight into con_in; the
    // address only advances after the strobe so the write sees the old one.
    always_comb begin
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        addr_d     = addr_q;
        wr_d       = 1'b0;
        data_d     = data_q;
        done_d     = done_q;
        ferr_d     = ferr_q | rx_ferr;

        if (rx_valid && !done_q) begin
            case (byte_idx_q)
                2'd0: lanes_d[7:0]   = rx_byte;
                2'd1: lanes_d[15:8]  = rx_byte;
                2'd2: lanes_d[23:16] = rx_byte;
                default: begin
                    data_d = {rx_byte, lanes_q};
                    wr_d   = 1'b1;
                end
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
        end

        if (wr_q) begin
            if (addr_q == LAST_ADDR) begin
                done_d = 1'b1;
            end else begin
                addr_d = addr_q + CON_ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            byte_idx_q <= 2'd0;
            lanes_q    <= 24'h0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            lanes_q    <= lanes_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign con_addr  = addr_q;
    assign con_write = {BYTES_PER_WORD{wr_q}};
    assign con_in    = data_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_datamemload.sv
// Directed bench for uart_datamemload at 4 clocks per bit and a 2-word memory:
// a table of single-word loads plus hand-written multi-cycle corner cases.
module tb_uart_datamemload;

    localparam int CPB = 4;
    localparam int NW  = 2;

    logic        CLK  = 1'b0;
    logic        nrst = 1'b0;
    logic        RX   = 1'b1;
    logic [10:0] con_addr;
    logic [3:0]  con_write;
    logic [31:0] con_in;
    logic        busy;
    logic        done;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    logic [10:0] wrAddr[$];
    logic [31:0] wrData[$];
    logic [3:0]  wrStrb[$];
    logic        doneAfter[$];
    logic        prevWr = 1'b0;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] expData;
    } wordVec_t;

    wordVec_t vecs[5];

    uart_datamemload #(
        .CLKS_PER_BIT(CPB),
        .NUM_WORDS   (NW)
    ) dut (
        .CLK       (CLK),
        .nrst      (nrst),
        .RX        (RX),
        .con_addr  (con_addr),
        .con_write (con_write),
        .con_in    (con_in),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    // Logs every strobed cycle plus the done flag one cycle after each strobe.
    always @(negedge CLK) begin
        if (prevWr) doneAfter.push_back(done);
        if (con_write !== 4'h0) begin
            wrAddr.push_back(con_addr);
            wrData.push_back(con_in);
            wrStrb.push_back(con_write);
        end
        prevWr = (con_write !== 4'h0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sendBit(input logic v);
        RX = v;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stopBit);
        RX = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[7:0], 1'b1);
        applyStimulus(w[15:8], 1'b1);
        applyStimulus(w[23:16], 1'b1);
        applyStimulus(w[31:24], 1'b1);
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        wrStrb.delete();
        doneAfter.delete();
    endtask

    task automatic doReset();
        RX   = 1'b1;
        nrst = 1'b0;
        idle(3);
        clearLog();
        nrst = 1'b1;
        idle(3);
    endtask

    function automatic logic [31:0] logAddr(input int i);
        return (wrAddr.size() > i) ? {21'h0, wrAddr[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] logData(input int i);
        return (wrData.size() > i) ? wrData[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] logStrb(input int i);
        return (wrStrb.size() > i) ? {28'h0, wrStrb[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] logDone(input int i);
        return (doneAfter.size() > i) ? {31'h0, doneAfter[i]} : 32'hxxxxxxxx;
    endfunction

    initial begin
        vecs[0] = '{b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, expData: 32'h12345678};
        vecs[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, expData: 32'h00000000};
        vecs[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, expData: 32'hFFFFFFFF};
        vecs[3] = '{b0: 8'hA5, b1: 8'h5A, b2: 8'hC3, b3: 8'h3C, expData: 32'h3CC35AA5};
        vecs[4] = '{b0: 8'h01, b1: 8'h00, b2: 8'h00, b3: 8'h80, expData: 32'h80000001};

        // Reset values while nrst is held low
        idle(3);
        checkOutput("rst_addr", {21'h0, con_addr}, 32'h0);
        checkOutput("rst_write", {28'h0, con_write}, 32'h0);
        checkOutput("rst_in", con_in, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_ferr", {31'h0, frame_err}, 32'h0);
        nrst = 1'b1;
        idle(3);

        // Single-word loads from the table
        for (int v = 0; v < 5; v++) begin
            doReset();
            applyStimulus(vecs[v].b0, 1'b1);
            applyStimulus(vecs[v].b1, 1'b1);
            applyStimulus(vecs[v].b2, 1'b1);
            applyStimulus(vecs[v].b3, 1'b1);
            idle(8);
            checkOutput($sformatf("vec%0d_nwrites", v), wrAddr.size(), 32'd1);
            checkOutput($sformatf("vec%0d_addr", v), logAddr(0), 32'd0);
            checkOutput($sformatf("vec%0d_data", v), logData(0), vecs[v].expData);
            checkOutput($sformatf("vec%0d_strb", v), logStrb(0), 32'hF);
            checkOutput($sformatf("vec%0d_busy", v), {31'h0, busy}, 32'h0);
            checkOutput($sformatf("vec%0d_ferr", v), {31'h0, frame_err}, 32'h0);
            checkOutput($sformatf("vec%0d_addr_after", v), {21'h0, con_addr}, 32'd1);
            checkOutput($sformatf("vec%0d_in_hold", v), con_in, vecs[v].expData);
            checkOutput($sformatf("vec%0d_done", v), {31'h0, done}, 32'h0);
        end

        // Two sequential words fill the 2-word memory
        doReset();
        sendWord(32'h04030201);
        sendWord(32'h08070605);
        idle(8);
        checkOutput("seq_nwrites", wrAddr.size(), 32'd2);
        checkOutput("seq_addr0", logAddr(0), 32'd0);
        checkOutput("seq_data0", logData(0), 32'h04030201);
        checkOutput("seq_addr1", logAddr(1), 32'd1);
        checkOutput("seq_data1", logData(1), 32'h08070605);
        checkOutput("seq_done_after0", logDone(0), 32'h0);
        checkOutput("seq_done_after1", logDone(1), 32'h1);
        checkOutput("seq_done", {31'h0, done}, 32'h1);

        // Bad stop bit: sticky error, byte dropped, index not advanced
        doReset();
        applyStimulus(8'hAA, 1'b0);
        idle(8);
        checkOutput("ferr_set", {31'h0, frame_err}, 32'h1);
        checkOutput("ferr_nowrite", wrAddr.size(), 32'd0);
        sendWord(32'h44332211);
        idle(8);
        checkOutput("ferr_sticky", {31'h0, frame_err}, 32'h1);
        checkOutput("ferr_nwrites", wrAddr.size(), 32'd1);
        checkOutput("ferr_addr", logAddr(0), 32'd0);
        checkOutput("ferr_data", logData(0), 32'h44332211);

        // One-cycle low glitch is rejected in START
        doReset();
        RX = 1'b0;
        idle(1);
        RX = 1'b1;
        idle(3);
        checkOutput("glitch_busy_high", {31'h0, busy}, 32'h1);
        idle(10);
        checkOutput("glitch_busy_low", {31'h0, busy}, 32'h0);
        checkOutput("glitch_ferr", {31'h0, frame_err}, 32'h0);
        checkOutput("glitch_nowrite", wrAddr.size(), 32'd0);
        sendWord(32'hDEADBEEF);
        idle(8);
        checkOutput("glitch_then_addr", logAddr(0), 32'd0);
        checkOutput("glitch_then_data", logData(0), 32'hDEADBEEF);

        // Done: third word must not write and address holds
        doReset();
        sendWord(32'h11111111);
        sendWord(32'h22222222);
        sendWord(32'h33333333);
        idle(8);
        checkOutput("done_nwrites", wrAddr.size(), 32'd2);
        checkOutput("done_addr1", logAddr(1), 32'd1);
        checkOutput("done_data1", logData(1), 32'h22222222);
        checkOutput("done_flag", {31'h0, done}, 32'h1);
        checkOutput("done_addr_hold", {21'h0, con_addr}, 32'd1);
        checkOutput("done_in_hold", con_in, 32'h22222222);

        // Asynchronous reset in the middle of DATA bit 3
        doReset();
        sendWord(32'hCAFEF00D);
        idle(8);
        checkOutput("mid_pre_addr", {21'h0, con_addr}, 32'd1);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        RX = 1'b1;
        idle(2);
        checkOutput("mid_pre_busy", {31'h0, busy}, 32'h1);
        #2 nrst = 1'b0;
        #1;
        checkOutput("mid_addr", {21'h0, con_addr}, 32'h0);
        checkOutput("mid_in", con_in, 32'h0);
        checkOutput("mid_busy", {31'h0, busy}, 32'h0);
        checkOutput("mid_write", {28'h0, con_write}, 32'h0);
        checkOutput("mid_done", {31'h0, done}, 32'h0);
        idle(3);
        clearLog();
        nrst = 1'b1;
        idle(3);
        sendWord(32'h87654321);
        idle(8);
        checkOutput("mid_after_nwrites", wrAddr.size(), 32'd1);
        checkOutput("mid_after_addr", logAddr(0), 32'd0);
        checkOutput("mid_after_data", logData(0), 32'h87654321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
